os_block_assembler: RTL and testbench
=====================================

Name: os_block_assembler

Overview:
- Per-lane receive stage directly upstream of the ordered-set checker in the RX LTSSM path.
- Collects post-descrambler 128b/130b symbol beats into complete 16-symbol blocks and classifies each block.
- Emits one 128-bit ordered set plus a single-cycle valid pulse per good ordered-set block. Data blocks are dropped; framing faults are flagged.
- One instance per lane; instantiated LANESNUMBER times by the lane wrapper.

Parameters:
- DATAWIDTH, 32, symbols-per-beat width in bits; legal values 8, 16, 32, 64; BEATS = 128/DATAWIDTH.
- TSONLY, 1, when 1 only TS1/TS2 blocks produce orderedset_valid; when 0 every ordered-set block does.

Ports:
- clk  in  1  receive clock.
- reset  in  1  asynchronous, active-low.
- data_in  in  DATAWIDTH  symbol beat; lowest-numbered symbol in [7:0].
- data_valid  in  1  data_in valid this cycle; low = stall, no beat consumed.
- block_start  in  1  qualifies data_in as beat 0 of a new block; meaningful only with data_valid.
- sync_header  in  2  sync header of the block; sampled only on a beat with block_start.
- orderedset  out  128  assembled block; symbol i at [8i+7:8i]; held between pulses.
- orderedset_valid  out  1  one-cycle pulse per forwarded block.
- os_type  out  2  0 = TS1 (sym0 0x1E), 1 = TS2 (0x2D), 2 = SKP (0xAA), 3 = other; valid with orderedset_valid.
- framing_error  out  1  one-cycle pulse on a framing fault.

Behaviour:
- Reset: state IDLE, beat counter 0, orderedset 0, orderedset_valid 0, os_type 0, framing_error 0, shift register 0.
- States:
  - IDLE: no block in progress.
  - COLLECT_OS: collecting an ordered-set block (sync_header 2'b01).
  - SKIP_DATA: consuming a data block (sync_header 2'b10) without storing it.
- IDLE:
  - data_valid & block_start & sync=01: store beat 0, counter = 1, go to COLLECT_OS.
  - sync=10: counter = 1, go to SKIP_DATA.
  - sync=00 or 11: pulse framing_error next cycle, stay in IDLE.
  - data_valid without block_start: beat discarded; pulse framing_error; stay in IDLE.
- COLLECT_OS / SKIP_DATA:
  - Each data_valid beat without block_start is stored at symbol offset counter*(DATAWIDTH/8) (COLLECT_OS only) and increments the counter.
  - On the final beat (counter == BEATS-1), return to IDLE. In COLLECT_OS, also latch the full 128 bits into orderedset and decode os_type from symbol 0. orderedset_valid pulses the following cycle (latency 1 clk after the final beat), unless TSONLY=1 and os_type > 1.
  - When TSONLY suppresses a block, orderedset is not updated.
- Early block_start mid-block:
  - Current block is aborted; framing_error pulses.
  - The new beat is handled exactly as a block start from IDLE in the same cycle. No gap cycle is allowed.
- data_valid low: hold all state; counter does not advance; no timeout.
- BEATS=1 (DATAWIDTH 128 is not legal): not supported. With DATAWIDTH=64, BEATS=2 and the start beat is also the beat at counter 0.
- Counter width: clog2(BEATS), minimum 1 bit; it wraps only via explicit return to IDLE.
- framing_error and orderedset_valid are mutually exclusive except in one case: a final beat completes in the same cycle an error is detected. That case cannot arise, because block_start on the final beat counts as an abort.
- Async reset mid-block: block discarded; no pulse after release.

Decomposition:
- Shared package (rx_ltssm_pkg):
  - symbol constants TS1_ID 8'h1E, TS2_ID 8'h2D, SKP_ID 8'hAA, PAD 8'hF7;
  - sync header constants SH_OS 2'b01, SH_DATA 2'b10;
  - os_type encodings;
  - assembler state enum.
- One natural sub-module: os_type_decode (combinational symbol-0 classifier), reusable by the checker side.

Test Plan:
- DATAWIDTH=32, TSONLY=1: block_start+sync 01, four beats with sym0 0x1E and sym1..15 = 0x01..0x0F, no stalls -> orderedset[7:0]=0x1E, [127:120]=0x0F; orderedset_valid high exactly one cycle, 1 clk after beat 3; os_type=0.
- Same TS2 block (sym0 0x2D) with data_valid low for 3 cycles between beats 1 and 2 -> single pulse after the last beat; os_type=1; orderedset correct.
- Data block (sync 10, 4 beats) followed by a TS1 block -> no pulse for the data block; one pulse for TS1; framing_error never asserted.
- block_start with sync 01 at beat 2 of an in-progress block -> framing_error one cycle; the new block completes after 3 further beats and pulses valid; the aborted block is never output.
- Sync header 2'b11 at block start, then 3 beats without block_start -> 4 framing_error pulses total; no valid; state ends IDLE.
- TSONLY=0, SKP block (sym0 0xAA) -> pulse with os_type=2; TSONLY=1 same stimulus -> no pulse, orderedset unchanged; reset asserted mid-block -> all outputs 0, no pulse after release.

Source files
------------

// File: rtl/rx_ltssm_pkg.sv
// Shared RX LTSSM definitions: symbol IDs, sync headers, ordered-set type codes
// and the block assembler state encoding.
`default_nettype none

package rx_ltssm_pkg;

  localparam logic [7:0] TS1_ID = 8'h1E;
  localparam logic [7:0] TS2_ID = 8'h2D;
  localparam logic [7:0] SKP_ID = 8'hAA;
  localparam logic [7:0] PAD    = 8'hF7;

  localparam logic [1:0] SH_OS   = 2'b01;
  localparam logic [1:0] SH_DATA = 2'b10;

  localparam logic [1:0] OS_TS1   = 2'd0;
  localparam logic [1:0] OS_TS2   = 2'd1;
  localparam logic [1:0] OS_SKP   = 2'd2;
  localparam logic [1:0] OS_OTHER = 2'd3;

  typedef enum logic [1:0] {
    ASM_IDLE       = 2'd0,
    ASM_COLLECT_OS = 2'd1,
    ASM_SKIP_DATA  = 2'd2
  } asm_state_t;

endpackage

`default_nettype wire

// File: rtl/os_type_decode.sv
// Combinational ordered-set classifier keyed on symbol 0 of a block.
`default_nettype none

module os_type_decode
  import rx_ltssm_pkg::*;
(
  input  logic [7:0] sym0,
  output logic [1:0] os_type
);

  always_comb begin
    case (sym0)
      TS1_ID:  os_type = OS_TS1;
      TS2_ID:  os_type = OS_TS2;
      SKP_ID:  os_type = OS_SKP;
      default: os_type = OS_OTHER;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/os_block_assembler.sv
// Per-lane 128b/130b block assembler: gathers symbol beats into 16-symbol blocks,
// forwards ordered sets with a one-cycle valid pulse and flags framing faults.
`default_nettype none

module os_block_assembler
  import rx_ltssm_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int TSONLY    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATAWIDTH-1:0] data_in,
  input  logic                 data_valid,
  input  logic                 block_start,
  input  logic [1:0]           sync_header,
  output logic [127:0]         orderedset,
  output logic                 orderedset_valid,
  output logic [1:0]           os_type,
  output logic                 framing_error
);

  localparam int BEATS = 128 / DATAWIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  asm_state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next, store_idx;
  logic          store, complete, err_next, forward;

  // The final beat is never stored: it is merged straight into the output word.
  logic [128-DATAWIDTH-1:0] blk;
  logic [127:0]             full_block;
  logic [1:0]               decoded_type;

  assign full_block = {data_in, blk};

  os_type_decode u_decode (
    .sym0    (full_block[7:0]),
    .os_type (decoded_type)
  );

  assign forward = complete && ((TSONLY == 0) || (decoded_type <= OS_TS2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ASM_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    store      = 1'b0;
    store_idx  = cnt;
    complete   = 1'b0;
    err_next   = 1'b0;
    if (data_valid) begin
      if (block_start) begin
        // A start mid-block aborts the old block and is taken as a fresh start.
        err_next  = (state != ASM_IDLE);
        store_idx = '0;
        cnt_next  = CW'(1);
        case (sync_header)
          SH_OS: begin
            state_next = ASM_COLLECT_OS;
            store      = 1'b1;
          end
          SH_DATA: state_next = ASM_SKIP_DATA;
          default: begin
            state_next = ASM_IDLE;
            cnt_next   = '0;
            err_next   = 1'b1;
          end
        endcase
      end else begin
        case (state)
          ASM_COLLECT_OS: begin
            if (cnt == LAST_BEAT) begin
              complete   = 1'b1;
              state_next = ASM_IDLE;
              cnt_next   = '0;
            end else begin
              store    = 1'b1;
              cnt_next = cnt + 1'b1;
            end
          end
          ASM_SKIP_DATA: begin
            if (cnt == LAST_BEAT) begin
              state_next = ASM_IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
          default: begin
            state_next = ASM_IDLE;
            err_next   = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk <= '0;
    end else if (store) begin
      for (int b = 0; b < BEATS - 1; b++) begin
        if (store_idx == CW'(b)) begin
          blk[b*DATAWIDTH +: DATAWIDTH] <= data_in;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      orderedset       <= '0;
      orderedset_valid <= 1'b0;
      os_type          <= OS_TS1;
      framing_error    <= 1'b0;
    end else begin
      orderedset_valid <= forward;
      framing_error    <= err_next;
      if (forward) begin
        orderedset <= full_block;
        os_type    <= decoded_type;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_os_block_assembler.sv
// Directed self-checking bench for os_block_assembler (DATAWIDTH=32, TSONLY=1 and 0).
`default_nettype none

module tb_os_block_assembler;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  data_in = '0;
  logic         data_valid = 1'b0;
  logic         block_start = 1'b0;
  logic [1:0]   sync_header = 2'b00;

  logic [127:0] os_a, os_b;
  logic         v_a, v_b, fe_a, fe_b;
  logic [1:0]   t_a, t_b;

  int n_cmp = 0;
  int n_err = 0;
  int vcnt_a = 0, fcnt_a = 0, vcnt_b = 0, fcnt_b = 0;

  always #5 clk = ~clk;

  os_block_assembler #(.DATAWIDTH(32), .TSONLY(1)) u_dut_a (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .block_start(block_start), .sync_header(sync_header),
    .orderedset(os_a), .orderedset_valid(v_a), .os_type(t_a), .framing_error(fe_a)
  );

  os_block_assembler #(.DATAWIDTH(32), .TSONLY(0)) u_dut_b (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .block_start(block_start), .sync_header(sync_header),
    .orderedset(os_b), .orderedset_valid(v_b), .os_type(t_b), .framing_error(fe_b)
  );

  always @(negedge clk) begin
    if (v_a)  vcnt_a++;
    if (fe_a) fcnt_a++;
    if (v_b)  vcnt_b++;
    if (fe_b) fcnt_b++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; checks after a tick see the
  // outputs produced by the preceding rising edge.
  task automatic tick(input logic v, input logic s, input logic [1:0] sh, input logic [31:0] d);
    @(negedge clk);
    data_valid  = v;
    block_start = s;
    sync_header = sh;
    data_in     = d;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 2'b00, 32'h0);
  endtask

  task automatic send_block(input logic [1:0] sh, input logic [127:0] blk);
    tick(1'b1, 1'b1, sh, blk[31:0]);
    tick(1'b1, 1'b0, 2'b00, blk[63:32]);
    tick(1'b1, 1'b0, 2'b00, blk[95:64]);
    tick(1'b1, 1'b0, 2'b00, blk[127:96]);
  endtask

  localparam logic [127:0] TS1_BLK = 128'h0F0E0D0C_0B0A0908_07060504_0302011E;
  localparam logic [127:0] TS2_BLK = 128'h0F0E0D0C_0B0A0908_07060504_0302012D;
  localparam logic [127:0] SKP_BLK = 128'h0F0E0D0C_0B0A0908_07060504_030201AA;
  localparam logic [127:0] DAT_BLK = 128'h11223344_55667788_99AABBCC_DDEEFF00;

  int va0, fa0, vb0;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_os", os_a, '0);
    chk("rst_valid", {127'd0, v_a}, 128'd0);
    chk("rst_type", {126'd0, t_a}, 128'd0);
    chk("rst_ferr", {127'd0, fe_a}, 128'd0);
    reset = 1'b1;
    idle();

    // TS1 block, no stalls
    va0 = vcnt_a; fa0 = fcnt_a;
    tick(1'b1, 1'b1, 2'b01, TS1_BLK[31:0]);
    tick(1'b1, 1'b0, 2'b00, TS1_BLK[63:32]);
    tick(1'b1, 1'b0, 2'b00, TS1_BLK[95:64]);
    tick(1'b1, 1'b0, 2'b00, TS1_BLK[127:96]);
    chk("ts1_novalid_early", {127'd0, v_a}, 128'd0);
    idle();
    chk("ts1_valid", {127'd0, v_a}, 128'd1);
    chk("ts1_os", os_a, TS1_BLK);
    chk("ts1_sym0", {120'd0, os_a[7:0]}, 128'h1E);
    chk("ts1_sym15", {120'd0, os_a[127:120]}, 128'h0F);
    chk("ts1_type", {126'd0, t_a}, 128'd0);
    idle();
    chk("ts1_pulse_ends", {127'd0, v_a}, 128'd0);
    chk("ts1_pulses", 128'(vcnt_a - va0), 128'd1);

    // TS2 block with a 3-cycle stall between beats 1 and 2
    va0 = vcnt_a;
    tick(1'b1, 1'b1, 2'b01, TS2_BLK[31:0]);
    tick(1'b1, 1'b0, 2'b00, TS2_BLK[63:32]);
    idle(); idle(); idle();
    chk("ts2_stall_novalid", {127'd0, v_a}, 128'd0);
    tick(1'b1, 1'b0, 2'b00, TS2_BLK[95:64]);
    tick(1'b1, 1'b0, 2'b00, TS2_BLK[127:96]);
    idle();
    chk("ts2_valid", {127'd0, v_a}, 128'd1);
    chk("ts2_type", {126'd0, t_a}, 128'd1);
    chk("ts2_os", os_a, TS2_BLK);
    idle();
    chk("ts2_pulses", 128'(vcnt_a - va0), 128'd1);

    // Data block then TS1 block
    va0 = vcnt_a;
    send_block(2'b10, DAT_BLK);
    idle();
    chk("data_nopulse", 128'(vcnt_a - va0), 128'd0);
    send_block(2'b01, TS1_BLK);
    idle(); idle();
    chk("data_ts1_pulses", 128'(vcnt_a - va0), 128'd1);
    chk("data_ts1_os", os_a, TS1_BLK);
    chk("data_ts1_noferr", 128'(fcnt_a - fa0), 128'd0);

    // Early block_start at beat 2 of a TS1 block, restarting as TS2
    va0 = vcnt_a; fa0 = fcnt_a;
    tick(1'b1, 1'b1, 2'b01, TS1_BLK[31:0]);
    tick(1'b1, 1'b0, 2'b00, TS1_BLK[63:32]);
    tick(1'b1, 1'b1, 2'b01, TS2_BLK[31:0]);
    tick(1'b1, 1'b0, 2'b00, TS2_BLK[63:32]);
    chk("abort_ferr", {127'd0, fe_a}, 128'd1);
    tick(1'b1, 1'b0, 2'b00, TS2_BLK[95:64]);
    tick(1'b1, 1'b0, 2'b00, TS2_BLK[127:96]);
    idle();
    chk("abort_new_valid", {127'd0, v_a}, 128'd1);
    chk("abort_new_os", os_a, TS2_BLK);
    idle();
    chk("abort_pulses", 128'(vcnt_a - va0), 128'd1);
    chk("abort_ferr_count", 128'(fcnt_a - fa0), 128'd1);

    // Bad sync header then three stray beats
    va0 = vcnt_a; fa0 = fcnt_a;
    send_block(2'b11, TS1_BLK);
    idle(); idle();
    chk("badsh_ferr_count", 128'(fcnt_a - fa0), 128'd4);
    chk("badsh_nopulse", 128'(vcnt_a - va0), 128'd0);
    send_block(2'b01, TS1_BLK);
    idle(); idle();
    chk("badsh_then_idle_ok", 128'(vcnt_a - va0), 128'd1);
    chk("badsh_no_extra_ferr", 128'(fcnt_a - fa0), 128'd4);

    // SKP block: forwarded only when TSONLY=0
    va0 = vcnt_a; vb0 = vcnt_b;
    send_block(2'b01, SKP_BLK);
    idle();
    chk("skp_b_valid", {127'd0, v_b}, 128'd1);
    chk("skp_b_type", {126'd0, t_b}, 128'd2);
    chk("skp_b_os", os_b, SKP_BLK);
    idle();
    chk("skp_a_nopulse", 128'(vcnt_a - va0), 128'd0);
    chk("skp_a_os_held", os_a, TS1_BLK);
    chk("skp_a_type_held", {126'd0, t_a}, 128'd0);

    // Async reset in the middle of a block
    va0 = vcnt_a; vb0 = vcnt_b;
    tick(1'b1, 1'b1, 2'b01, TS1_BLK[31:0]);
    tick(1'b1, 1'b0, 2'b00, TS1_BLK[63:32]);
    #2 reset = 1'b0;
    #1;
    chk("mrst_os", os_a, '0);
    chk("mrst_os_b", os_b, '0);
    chk("mrst_type_b", {126'd0, t_b}, 128'd0);
    chk("mrst_ferr", {127'd0, fe_a}, 128'd0);
    idle();
    reset = 1'b1;
    idle(); idle(); idle();
    chk("mrst_nopulse_a", 128'(vcnt_a - va0), 128'd0);
    chk("mrst_nopulse_b", 128'(vcnt_b - vb0), 128'd0);
    chk("mrst_valid_low", {127'd0, v_a}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
